// File: rtl/kbd_event_fifo_if.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo_if
// Bundles the scan-code input, the event handshake and the status outputs of
// kbd_event_fifo.
//   code      16  held PS/2 scan code {prefix, scan}
//   ev_ready   1  consumer accepts the head event
//   clr_ovf    1  clear the sticky overflow flag
//   ev_valid   1  FIFO non-empty, ev_data valid
//   ev_data   10  {brk, ext, scan}; 26 bits {ts, brk, ext, scan} when
//                 KBD_EVENT_TIMESTAMP_EN is defined
//   ev_count AW+1 stored entries, 0..DEPTH
//   overflow   1  sticky, an event was dropped
// Modports: master = producer/consumer side, slave = the FIFO block.
// Optional feature macro: KBD_EVENT_TIMESTAMP_EN.
// ---------------------------------------------------------------------------
interface kbd_event_fifo_if #(
  parameter int unsigned AW = 3
);
`ifdef KBD_EVENT_TIMESTAMP_EN
  localparam int unsigned DW = 26;
`else
  localparam int unsigned DW = 10;
`endif

  logic [15:0]   code;
  logic          ev_ready;
  logic          clr_ovf;
  logic          ev_valid;
  logic [DW-1:0] ev_data;
  logic [AW:0]   ev_count;
  logic          overflow;

  modport master (
    output code, ev_ready, clr_ovf,
    input  ev_valid, ev_data, ev_count, overflow
  );

  modport slave (
    input  code, ev_ready, clr_ovf,
    output ev_valid, ev_data, ev_count, overflow
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// ---------------------------------------------------------------------------
// kbd_event_fifo
// Watches the held scan code from the PS/2 receiver, turns every change into
// a key event {brk, ext, scan} and queues it in a show-ahead FIFO.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   kbd_event_fifo_if.slave (code in, event handshake and status out)
// Parameters:
//   DEPTH FIFO entries, power of two >= 2
//   AW    pointer width, log2(DEPTH)
// Optional feature macro: KBD_EVENT_TIMESTAMP_EN stores a 16-bit free-running
// cycle count with each event (ev_data becomes {ts, brk, ext, scan}).
// ---------------------------------------------------------------------------
module kbd_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  kbd_event_fifo_if.slave  bus
);

  localparam int unsigned EW = 10;
`ifdef KBD_EVENT_TIMESTAMP_EN
  localparam int unsigned DW = EW + 16;
`else
  localparam int unsigned DW = EW;
`endif
  localparam int unsigned CW = AW + 1;

  // Stage 1: code capture and previous-code history
  logic [15:0]   r_code;
  logic [15:0]   r_code_prev;

  // Stage 2: registered push request and decoded event
  logic          r_push;
  logic [EW-1:0] r_ev;

  // FIFO state
  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_valid;
  logic          r_ovf;

  // Decode and FIFO next-state wires
  logic          w_dec_ok;
  logic          w_brk;
  logic          w_ext;
  logic          w_change;
  logic          w_pop;
  logic          w_full;
  logic          w_wr_en;
  logic          w_drop;
  logic [DW-1:0] w_wr_data;
  logic [AW-1:0] w_wr_ptr_nxt;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_count_nxt;
  logic          w_valid_nxt;
  logic          w_ovf_nxt;

  // Code history; code_prev starts at 0 so a non-zero code after reset fires once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code      <= 16'h0000;
      r_code_prev <= 16'h0000;
    end else begin
      r_code      <= bus.code;
      r_code_prev <= r_code;
    end
  end

  // Decode of the captured code into make/break/extended
  always_comb begin
    w_dec_ok = 1'b0;
    w_brk    = 1'b0;
    w_ext    = 1'b0;
    if (r_code == 16'h0000) begin
      w_dec_ok = 1'b0;
    end else if (r_code[15:8] == 8'h00) begin
      w_dec_ok = 1'b1;
    end else if (r_code[15:8] == 8'hE0) begin
      // E0 F0 is the extended-release prefix pair, not a key
      w_dec_ok = (r_code[7:0] != 8'hF0);
      w_ext    = 1'b1;
    end else if (r_code[15:8] == 8'hF0) begin
      w_dec_ok = 1'b1;
      w_brk    = 1'b1;
    end else begin
      w_dec_ok = 1'b0;
    end
  end

  assign w_change = w_dec_ok & (r_code != r_code_prev);

  // Push request is registered one edge after the change is seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push <= 1'b0;
      r_ev   <= '0;
    end else begin
      r_push <= w_change;
      r_ev   <= {w_brk, w_ext, r_code[7:0]};
    end
  end

`ifdef KBD_EVENT_TIMESTAMP_EN
  logic [15:0] r_ts;

  // Free-running timestamp, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts <= 16'h0000;
    end else begin
      r_ts <= r_ts + 16'd1;
    end
  end

  assign w_wr_data = {r_ts, r_ev};
`else
  assign w_wr_data = r_ev;
`endif

  // FIFO next state; a push into a full FIFO still lands when a pop frees the
  // head in the same cycle (wr_ptr == rd_ptr then, and the head is consumed)
  always_comb begin
    w_pop        = r_valid & bus.ev_ready;
    w_full       = (r_count == CW'(DEPTH));
    w_wr_en      = r_push & (~w_full | w_pop);
    w_drop       = r_push & w_full & ~w_pop;
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_ovf_nxt    = r_ovf;

    if (w_wr_en) begin
      w_wr_ptr_nxt = r_wr_ptr + AW'(1);
    end
    if (w_pop) begin
      w_rd_ptr_nxt = r_rd_ptr + AW'(1);
    end

    case ({w_wr_en, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    // A fresh drop outranks a clear request in the same cycle
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
    end else if (bus.clr_ovf) begin
      w_ovf_nxt = 1'b0;
    end

    w_valid_nxt = (w_count_nxt != '0);
  end

  // FIFO control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_valid  <= w_valid_nxt;
      r_ovf    <= w_ovf_nxt;
    end
  end

  // Storage array; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // Show-ahead head and status
  assign bus.ev_data  = r_mem[r_rd_ptr];
  assign bus.ev_valid = r_valid;
  assign bus.ev_count = r_count;
  assign bus.overflow = r_ovf;

endmodule
